// File: rtl/piso_frame_tx.sv
// -----------------------------------------------------------------------------
// piso_frame_tx
//
// Parallel-in / serial-out frame transmitter. Each accepted byte is sent as a
// 10-bit frame: a start bit (0), data bits LSB first, then a stop bit (1).
// Every bit is held on the line for BIT_TICKS clock cycles. A one-entry
// holding register lets a second byte be queued while a frame is in flight.
// That byte follows the current frame with no idle gap.
//
// Parameters
//   BIT_TICKS : sr_clk cycles per serial bit (1..256)
//
// Ports
//   sr_clk   in   sole clock, rising edge
//   reset    in   asynchronous active-low reset
//   data_in  in   [7:0] byte to transmit
//   load     in   request to accept data_in (taken only when ready is high)
//   ready    out  holding register empty, a load will be accepted
//   data_out out  registered serial line, idles at 1
//   busy     out  high while a frame is on the line
//   done     out  one-cycle pulse on the edge that ends each stop bit
// -----------------------------------------------------------------------------
module piso_frame_tx #(
    parameter int BIT_TICKS = 1
) (
    input  logic       sr_clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       load,
    output logic       ready,
    output logic       data_out,
    output logic       busy,
    output logic       done
);

    // A one-cycle bit still needs a 1-bit counter so the compare is well formed.
    localparam int                TICK_W    = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [TICK_W-1:0] tick_q,      tick_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic [7:0]        shift_q,     shift_d;
    logic [7:0]        hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    logic              data_out_q,  data_out_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;

    logic              accept;
    logic              tick_last;

    // ready comes straight from the holding-register flag, so it is a flop output.
    assign ready     = ~hold_full_q;
    assign accept    = load & ~hold_full_q;
    assign tick_last = (tick_q == TICK_LAST);

    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        data_out_d  = data_out_q;
        done_d      = 1'b0;

        // Mid-frame loads are parked in the holding register. The stop-bit
        // branch below overrides this when the byte can go straight out.
        if ((state_q != IDLE) && accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                data_out_d = 1'b1;
                if (accept) begin
                    // Start bit goes out on the accept edge itself.
                    shift_d    = data_in;
                    state_d    = START;
                    data_out_d = 1'b0;
                    tick_d     = '0;
                    bit_idx_d  = '0;
                end
            end

            START: begin
                if (tick_last) begin
                    tick_d     = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                    data_out_d = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            DATA: begin
                if (tick_last) begin
                    tick_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d    = STOP;
                        data_out_d = 1'b1;
                    end else begin
                        bit_idx_d  = bit_idx_q + 3'd1;
                        data_out_d = shift_q[0];
                        shift_d    = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            STOP: begin
                if (tick_last) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    done_d    = 1'b1;
                    if (hold_full_q) begin
                        // Queued byte starts immediately; ready returns high.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        state_d     = START;
                        data_out_d  = 1'b0;
                    end else if (load) begin
                        // Empty holding register: send the new byte directly
                        // instead of parking it.
                        shift_d     = data_in;
                        hold_full_d = 1'b0;
                        state_d     = START;
                        data_out_d  = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        data_out_d = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + TICK_ONE;
                end
            end

            default: begin
                state_d    = IDLE;
                data_out_d = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge sr_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            data_out_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            data_out_q  <= data_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_piso_frame_tx
//
// Bench for piso_frame_tx with two instances: BIT_TICKS=1 and BIT_TICKS=4.
// The reference model keeps a per-cycle timeline of expected line levels for
// each instance. An accepted byte appends its whole frame to the timeline,
// and one pending byte is held while the line is busy. A compare process
// checks every cycle against this model. Directed scenarios add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_piso_frame_tx;

    logic       sr_clk = 1'b0;
    logic       reset  = 1'b0;
    logic [7:0] din1   = 8'h00;
    logic [7:0] din4   = 8'h00;
    logic       load1  = 1'b0;
    logic       load4  = 1'b0;
    logic       rdy1, dout1, busy1, done1;
    logic       rdy4, dout4, busy4, done4;
    logic [7:0] rx;

    int checks = 0;
    int errors = 0;

    always #5 sr_clk = ~sr_clk;

    piso_frame_tx #(.BIT_TICKS(1)) dut1 (
        .sr_clk   (sr_clk),
        .reset    (reset),
        .data_in  (din1),
        .load     (load1),
        .ready    (rdy1),
        .data_out (dout1),
        .busy     (busy1),
        .done     (done1)
    );

    piso_frame_tx #(.BIT_TICKS(4)) dut4 (
        .sr_clk   (sr_clk),
        .reset    (reset),
        .data_in  (din4),
        .load     (load4),
        .ready    (rdy4),
        .data_out (dout4),
        .busy     (busy4),
        .done     (done4)
    );

    // Loopback receiver: 8-bit serial-in shift register on the same clock.
    always @(posedge sr_clk) rx <= {dout1, rx[7:1]};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         bt [2] = '{1, 4};
    bit         mq [2][$];
    logic [7:0] pend [2];
    bit         pend_v [2];
    bit         exp_done [2];

    function automatic void push_frame(input int i, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int t = 0; t < bt[i]; t++)
                mq[i].push_back(f[k]);
    endfunction

    task automatic model_step(input int i, input bit ld, input logic [7:0] d);
        bit popped;
        bit rdy;
        rdy    = !pend_v[i];
        popped = 1'b0;
        if (mq[i].size() > 0) begin
            void'(mq[i].pop_front());
            popped = 1'b1;
        end
        exp_done[i] = popped && (mq[i].size() == 0);
        if (mq[i].size() == 0) begin
            if (pend_v[i]) begin
                push_frame(i, pend[i]);
                pend_v[i] = 1'b0;
            end else if (ld) begin
                push_frame(i, d);
            end
        end else if (ld && rdy) begin
            pend[i]   = d;
            pend_v[i] = 1'b1;
        end
    endtask

    function automatic logic exp_line(input int i);
        return (mq[i].size() > 0) ? mq[i][0] : 1'b1;
    endfunction

    initial forever begin
        @(posedge sr_clk or negedge reset);
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                pend_v[i]   = 1'b0;
                exp_done[i] = 1'b0;
            end
        end else begin
            model_step(0, load1, din1);
            model_step(1, load4, din4);
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge sr_clk);
        chk("mdl_dout_bt1",  dout1, exp_line(0));
        chk("mdl_busy_bt1",  busy1, mq[0].size() > 0);
        chk("mdl_done_bt1",  done1, exp_done[0]);
        chk("mdl_ready_bt1", rdy1,  !pend_v[0]);
        chk("mdl_dout_bt4",  dout4, exp_line(1));
        chk("mdl_busy_bt4",  busy4, mq[1].size() > 0);
        chk("mdl_done_bt4",  done4, exp_done[1]);
        chk("mdl_ready_bt4", rdy4,  !pend_v[1]);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        logic [10:0] seq26;
        bit          exp28 [22];
        int          bcnt;
        int          dcnt;
        int          dpos;
        int          dpos2;
        logic        e;

        exp28 = '{0,1,0,1,0,0,1,0,1,1,  0,0,0,1,1,1,1,0,0,1,  1,1};

        // Reset state
        repeat (2) @(negedge sr_clk);
        chk("rst_dout", dout1, 1'b1);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_done", done1, 1'b0);
        chk("rst_ready", rdy1, 1'b1);
        chk("rst_dout4", dout4, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge sr_clk);

        // Single frame 8'hE1, BIT_TICKS=1
        din1 = 8'hE1; load1 = 1'b1;
        bcnt = 0; dcnt = 0; dpos = -1; seq26 = '0;
        for (int c = 0; c < 11; c++) begin
            @(negedge sr_clk);
            load1 = 1'b0;
            seq26[c] = dout1;
            if (busy1) bcnt++;
            if (done1) begin dcnt++; dpos = c; end
        end
        chk("e1_bits", seq26, 11'h7C2);
        chk("e1_busy_cycles", bcnt, 10);
        chk("e1_done_count", dcnt, 1);
        chk("e1_done_pos", dpos, 10);

        // Loopback of 8'h5A into the serial-in receiver
        din1 = 8'h5A; load1 = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(negedge sr_clk);
            load1 = 1'b0;
            if (c == 9) chk("loopback_rx", rx, 8'h5A);
        end

        // Back-to-back A5 then 3C, plus an ignored FF while the holder is full
        din1 = 8'hA5; load1 = 1'b1;
        dcnt = 0; dpos = -1; dpos2 = -1;
        for (int c = 0; c < 22; c++) begin
            @(negedge sr_clk);
            load1 = 1'b0;
            chk($sformatf("b2b_bit%0d", c), dout1, exp28[c]);
            if (done1) begin
                if (dcnt == 0) dpos = c; else dpos2 = c;
                dcnt++;
            end
            if (c == 2)  chk("b2b_ready_c2", rdy1, 1'b1);
            if (c == 3)  chk("b2b_ready_c3", rdy1, 1'b0);
            if (c == 9)  chk("b2b_ready_c9", rdy1, 1'b0);
            if (c == 10) chk("b2b_ready_c10", rdy1, 1'b1);
            if (c == 2) begin din1 = 8'h3C; load1 = 1'b1; end
            if (c == 5) begin din1 = 8'hFF; load1 = 1'b1; end
        end
        chk("b2b_done_count", dcnt, 2);
        chk("b2b_done_pos1", dpos, 10);
        chk("b2b_done_pos2", dpos2, 20);
        chk("b2b_idle_busy", busy1, 1'b0);

        // BIT_TICKS=4, byte 8'h01
        din4 = 8'h01; load4 = 1'b1;
        bcnt = 0; dcnt = 0; dpos = -1;
        for (int c = 0; c < 42; c++) begin
            @(negedge sr_clk);
            load4 = 1'b0;
            e = (c < 4) ? 1'b0 : (c < 8) ? 1'b1 : (c < 36) ? 1'b0 : 1'b1;
            chk($sformatf("bt4_bit%0d", c), dout4, e);
            if (busy4) bcnt++;
            if (done4) begin dcnt++; dpos = c; end
        end
        chk("bt4_busy_cycles", bcnt, 40);
        chk("bt4_done_count", dcnt, 1);
        chk("bt4_done_pos", dpos, 40);

        // Reset during data bit 3 of 8'h81 with 8'h77 pending
        din1 = 8'h81; load1 = 1'b1;
        @(negedge sr_clk);                          // c0: start bit
        load1 = 1'b0;
        @(negedge sr_clk);                          // c1: bit 0
        din1 = 8'h77; load1 = 1'b1;
        @(negedge sr_clk);                          // c2: bit 1
        load1 = 1'b0;
        @(negedge sr_clk);                          // c3: bit 2
        chk("rst31_pending_ready", rdy1, 1'b0);
        @(negedge sr_clk);                          // c4: bit 3
        chk("rst31_bit3", dout1, 1'b0);
        chk("rst31_busy_before", busy1, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("rst31_dout_async", dout1, 1'b1);
        chk("rst31_busy_async", busy1, 1'b0);
        chk("rst31_ready_async", rdy1, 1'b1);
        chk("rst31_done_async", done1, 1'b0);
        repeat (2) @(negedge sr_clk);
        reset = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge sr_clk);
            chk($sformatf("rst31_idle_dout%0d", c), dout1, 1'b1);
            chk($sformatf("rst31_idle_busy%0d", c), busy1, 1'b0);
        end

        @(negedge sr_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_frame_tx.md
PISO_FRAME_TX -- requirements
Module: piso_frame_tx

Interface
REQ-001 SHALL have parameter BIT_TICKS, default 1, meaning sr_clk cycles each serial bit is held (legal 1..256).
REQ-002 SHALL have port sr_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of sr_clk).
REQ-004 SHALL have port data_in  input  8  parallel byte to transmit.
REQ-005 SHALL have port load  input  1  request to accept data_in, sampled on rising sr_clk.
REQ-006 SHALL have port ready  output  1  high when a load will be accepted (holding register empty).
REQ-007 SHALL have port data_out  output  1  serial line; idle level 1.
REQ-008 SHALL have port busy  output  1  high while a frame is on the line.
REQ-009 SHALL have port done  output  1  one-cycle pulse at end of each frame's stop bit.

Function
REQ-010 SHALL emit frames of 10 bits: start bit 0, data_in[0] first through data_in[7], stop bit 1.
REQ-011 SHALL hold every frame bit on data_out for exactly BIT_TICKS cycles, using a tick counter of clog2(BIT_TICKS) or more bits that wraps to 0 at BIT_TICKS-1.
REQ-012 SHALL implement states IDLE, START, DATA, STOP; a 3-bit bit index counts DATA bits 0..7.
REQ-013 SHALL transition: IDLE->START on accepted byte; START->DATA after BIT_TICKS cycles; DATA->STOP after bit index 7 completes; STOP->START if a byte is pending, else STOP->IDLE.
REQ-014 SHALL accept a byte only on a rising edge with load==1 and ready==1; load while ready==0 SHALL be ignored with no state change.
REQ-015 SHALL, in IDLE with load accepted at edge k, load the shift register directly and drive data_out=0 (START) from edge k; no extra latency cycle.
REQ-016 SHALL, outside IDLE, capture an accepted byte into a one-entry holding register, deasserting ready from the next edge until that byte moves to the shift register.
REQ-017 SHALL, at the final stop-bit tick with holding register full, move it into the shift register and enter START on the same edge (zero idle cycles between frames), reasserting ready.
REQ-018 SHALL, at the final stop-bit tick with holding register empty and load==1, transmit data_in directly, entering START on that edge.
REQ-019 SHALL drive data_out from a registered output, glitch-free; data_out==1 in IDLE.
REQ-020 SHALL assert busy in START, DATA, STOP; deassert only in IDLE.
REQ-021 SHALL pulse done for exactly one cycle on the edge ending each stop bit, including back-to-back frames.
REQ-022 SHALL NOT alter a frame in flight when data_in or load change mid-frame.

Reset
REQ-023 SHALL, while reset==0, force state IDLE, data_out=1, busy=0, done=0, ready=1, tick and bit counters 0, holding register empty.
REQ-024 SHALL abort any frame and discard any pending byte when reset asserts mid-operation; data_out returns to 1 asynchronously.
REQ-025 SHALL resume normal operation on the first rising sr_clk after reset deasserts (returns to 1).

Verification
REQ-026 BIT_TICKS=1, load 8'hE1 once -> data_out on successive cycles 0,1,0,0,0,0,1,1,1,1 then 1 idle; busy high 10 cycles; done pulses once on the 10th edge.
REQ-027 Loopback data_out into the 8-bit serial-in receiver on the same sr_clk, send 8'h5A -> receiver parallel output 8'h5A after 10 shifts.
REQ-028 BIT_TICKS=1, load 8'hA5 then 8'h3C during frame 1 -> 20 contiguous bits (A5 frame then 3C frame), no idle cycle, two done pulses 10 cycles apart, ready low from the accept until frame 2 start.
REQ-029 Frame in flight, holding register full, pulse load with 8'hFF -> byte ignored, only the two earlier frames transmitted.
REQ-030 BIT_TICKS=4, send 8'h01 -> each bit held 4 cycles, frame 40 cycles, done on edge 40.
REQ-031 Assert reset==0 at data bit 3 of 8'h81 with a byte pending -> data_out=1, busy=0, ready=1 immediately; no further frame after reset release until a new load.
